// File: rtl/key_repeat_decoder.sv
// -----------------------------------------------------------------------------
// key_repeat_decoder
//   Turns a stream of PS/2 set-2 scan-code bytes into per-channel key state:
//   a held level, a press/auto-repeat strobe and a release strobe. A small
//   prefix parser (E0 / F0) classifies each code as make or break, extended or
//   not; matching channels update their held level, and the most recently
//   pressed channel gets software-style auto-repeat.
//
// Ports
//   CLK_50M      in   system clock, all state on the rising edge
//   RSTn         in   synchronous active-low reset
//   ps2_byte     in   [7:0] scan-code byte from the PS/2 receiver
//   ps2_valid    in   one-cycle strobe, ps2_byte is new
//   key_held     out  [NUM_KEYS-1:0] level, key currently down
//   key_pulse    out  [NUM_KEYS-1:0] strobe, press or auto-repeat event
//   key_release  out  [NUM_KEYS-1:0] strobe, break code accepted
// -----------------------------------------------------------------------------
module key_repeat_decoder #(
   parameter int                    NUM_KEYS       = 4,
   parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = {8'h1D, 8'h23, 8'h1B, 8'h1C},
   parameter logic [NUM_KEYS-1:0]   KEY_EXT        = '0,
   parameter int                    REPEAT_DELAY   = 25_000_000,
   parameter int                    REPEAT_PERIOD  = 5_000_000,
   parameter int                    PREFIX_TIMEOUT = 100_000
) (
   input  logic                CLK_50M,
   input  logic                RSTn,
   input  logic [7:0]          ps2_byte,
   input  logic                ps2_valid,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_pulse,
   output logic [NUM_KEYS-1:0] key_release
);

   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW      = (RPT_MAX > 0) ? $clog2(RPT_MAX + 1) : 1;
   localparam int TW      = (PREFIX_TIMEOUT > 0) ? $clog2(PREFIX_TIMEOUT + 1) : 1;
   localparam int IW      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam bit RPT_EN  = (REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0);

   // The press cycle itself counts toward the delay, so the first repeat
   // lands REPEAT_DELAY cycles after the make byte (press pulse + DELAY-1).
   localparam logic [CW-1:0] DLY_LOAD = CW'((REPEAT_DELAY > 1) ? REPEAT_DELAY - 1 : 1);
   localparam logic [CW-1:0] PER_LOAD = CW'(REPEAT_PERIOD);
   localparam logic [TW-1:0] TMO_LAST = TW'((PREFIX_TIMEOUT > 0) ? PREFIX_TIMEOUT - 1 : 0);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_EXT     = 2'd1;
   localparam logic [1:0] ST_BRK     = 2'd2;
   localparam logic [1:0] ST_EXT_BRK = 2'd3;

   logic [1:0]          st_q, st_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic [NUM_KEYS-1:0] held_q, held_d;
   logic [NUM_KEYS-1:0] pulse_q, pulse_d;
   logic [NUM_KEYS-1:0] rel_q, rel_d;
   logic                tgt_vld_q, tgt_vld_d;
   logic [IW-1:0]       tgt_q, tgt_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   logic                mk_vld, brk_vld, code_ext;
   logic [NUM_KEYS-1:0] hit, press, rel;
   logic                expire;

   // ---------------- prefix parser ----------------
   always_comb begin
      st_d     = st_q;
      tmo_d    = tmo_q;
      mk_vld   = 1'b0;
      brk_vld  = 1'b0;
      code_ext = 1'b0;
      if (ps2_valid) begin
         tmo_d = '0;
         // E1 (pause-key prefix) is dropped everywhere without a state change
         if (ps2_byte != 8'hE1) begin
            case (st_q)
               ST_IDLE: begin
                  if (ps2_byte == 8'hE0)      st_d = ST_EXT;
                  else if (ps2_byte == 8'hF0) st_d = ST_BRK;
                  else                        mk_vld = 1'b1;
               end
               ST_EXT: begin
                  if (ps2_byte == 8'hF0) st_d = ST_EXT_BRK;
                  else if (ps2_byte != 8'hE0) begin
                     mk_vld   = 1'b1;
                     code_ext = 1'b1;
                     st_d     = ST_IDLE;
                  end
               end
               ST_BRK: begin
                  if (ps2_byte != 8'hF0) begin
                     brk_vld = 1'b1;
                     st_d    = ST_IDLE;
                  end
               end
               default: begin
                  if (ps2_byte != 8'hF0 && ps2_byte != 8'hE0) begin
                     brk_vld  = 1'b1;
                     code_ext = 1'b1;
                     st_d     = ST_IDLE;
                  end
               end
            endcase
         end
      end else if (st_q != ST_IDLE && PREFIX_TIMEOUT > 0) begin
         // stale prefix: a lost byte must not turn the next make into a break
         if (tmo_q == TMO_LAST) begin
            st_d  = ST_IDLE;
            tmo_d = '0;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
   end

   // ---------------- channel match ----------------
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_KEYS; i++)
         hit[i] = (ps2_byte == KEY_CODES[8*i +: 8]) && (code_ext == KEY_EXT[i]);
   end

   assign press  = {NUM_KEYS{mk_vld}}  & hit & ~held_q;
   assign rel    = {NUM_KEYS{brk_vld}} & hit &  held_q;
   assign expire = RPT_EN && tgt_vld_q && held_q[tgt_q] && (cnt_q == CW'(1));

   // ---------------- key state and auto-repeat ----------------
   always_comb begin
      held_d    = (held_q | press) & ~rel;
      rel_d     = rel;
      pulse_d   = press;
      tgt_vld_d = tgt_vld_q;
      tgt_d     = tgt_q;
      cnt_d     = cnt_q;

      if (expire) pulse_d[tgt_q] = 1'b1;

      if (tgt_vld_q) begin
         if (expire)              cnt_d = PER_LOAD;
         else if (cnt_q != '0)    cnt_d = cnt_q - CW'(1);
      end

      if (tgt_vld_q && rel[tgt_q]) begin
         tgt_vld_d = 1'b0;
         cnt_d     = '0;
      end

      // newest press owns the repeat; lowest index wins on duplicate codes
      if (|press) begin
         tgt_vld_d = RPT_EN;
         cnt_d     = DLY_LOAD;
         for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (press[i]) tgt_d = IW'(i);
      end
   end

   always_ff @(posedge CLK_50M) begin
      if (!RSTn) begin
         st_q      <= ST_IDLE;
         tmo_q     <= '0;
         held_q    <= '0;
         pulse_q   <= '0;
         rel_q     <= '0;
         tgt_vld_q <= 1'b0;
         tgt_q     <= '0;
         cnt_q     <= '0;
      end else begin
         st_q      <= st_d;
         tmo_q     <= tmo_d;
         held_q    <= held_d;
         pulse_q   <= pulse_d;
         rel_q     <= rel_d;
         tgt_vld_q <= tgt_vld_d;
         tgt_q     <= tgt_d;
         cnt_q     <= cnt_d;
      end
   end

   assign key_held    = held_q;
   assign key_pulse   = pulse_q;
   assign key_release = rel_q;

endmodule

// File: tb/tb_key_repeat_decoder.sv
// -----------------------------------------------------------------------------
// tb_key_repeat_decoder
//   Scoreboarded bench. The driver issues one cycle of stimulus per negedge and
//   pushes the expected outputs from a reference model that reasons in absolute
//   cycle numbers (repeat schedule, idle gap between bytes). A monitor pops one
//   expectation after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_key_repeat_decoder;

   localparam int                NK    = 5;
   localparam logic [8*NK-1:0]   CODES = {8'h6B, 8'h1D, 8'h23, 8'h1B, 8'h1C};
   localparam logic [NK-1:0]     KEXT  = 5'b10000;
   localparam int                DLY   = 10;
   localparam int                PER   = 4;
   localparam int                TMO   = 6;

   logic          CLK_50M = 1'b0;
   logic          RSTn = 1'b0;
   logic [7:0]    ps2_byte = 8'h00;
   logic          ps2_valid = 1'b0;
   logic [NK-1:0] key_held, key_pulse, key_release;

   key_repeat_decoder #(
      .NUM_KEYS(NK), .KEY_CODES(CODES), .KEY_EXT(KEXT),
      .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .PREFIX_TIMEOUT(TMO)
   ) dut (
      .CLK_50M(CLK_50M), .RSTn(RSTn), .ps2_byte(ps2_byte), .ps2_valid(ps2_valid),
      .key_held(key_held), .key_pulse(key_pulse), .key_release(key_release)
   );

   always #5 CLK_50M = ~CLK_50M;

   typedef struct {
      logic [NK-1:0] held;
      logic [NK-1:0] pulse;
      logic [NK-1:0] rel;
      int            cyc;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // ---------------- reference model ----------------
   int            k = 0;          // rising-edge index of the cycle being modelled
   logic [NK-1:0] m_held = '0;
   int            m_tgt = -1;
   int            m_next_rep = 0;
   bit            m_ext = 0, m_brk = 0;
   int            m_last_byte = 0;

   task automatic m_make(input logic [7:0] b, input bit e, inout exp_t x);
      int first = -1;
      for (int i = 0; i < NK; i++) begin
         if (CODES[8*i +: 8] == b && KEXT[i] == e && !m_held[i]) begin
            m_held[i] = 1'b1;
            x.pulse[i] = 1'b1;
            if (first < 0) first = i;
         end
      end
      if (first >= 0) begin
         m_tgt = first;
         m_next_rep = k + DLY - 1;
      end
   endtask

   task automatic m_break(input logic [7:0] b, input bit e, inout exp_t x);
      for (int i = 0; i < NK; i++) begin
         if (CODES[8*i +: 8] == b && KEXT[i] == e && m_held[i]) begin
            m_held[i] = 1'b0;
            x.rel[i] = 1'b1;
            if (m_tgt == i) m_tgt = -1;
         end
      end
   endtask

   task automatic model_cycle(input bit rst_n, input bit v, input logic [7:0] b, output exp_t x);
      x.pulse = '0;
      x.rel   = '0;
      x.cyc   = k;
      if (!rst_n) begin
         m_held = '0;
         m_tgt  = -1;
         m_ext  = 0;
         m_brk  = 0;
      end else begin
         if (m_tgt >= 0 && k == m_next_rep) begin
            x.pulse[m_tgt] = 1'b1;
            m_next_rep = m_next_rep + PER;
         end
         if (v) begin
            if ((m_ext || m_brk) && (k - m_last_byte - 1) >= TMO) begin
               m_ext = 0;
               m_brk = 0;
            end
            m_last_byte = k;
            if (b == 8'hE1) begin
               // dropped
            end else if (m_brk) begin
               if (!(b == 8'hF0 || (b == 8'hE0 && m_ext))) begin
                  m_break(b, m_ext, x);
                  m_ext = 0;
                  m_brk = 0;
               end
            end else if (m_ext) begin
               if (b == 8'hF0) m_brk = 1;
               else if (b != 8'hE0) begin
                  m_make(b, 1'b1, x);
                  m_ext = 0;
               end
            end else begin
               if (b == 8'hE0)      m_ext = 1;
               else if (b == 8'hF0) m_brk = 1;
               else                 m_make(b, 1'b0, x);
            end
         end
      end
      x.held = m_held;
   endtask

   // ---------------- driver helpers ----------------
   task automatic step(input bit rst_n, input bit v, input logic [7:0] b);
      exp_t x;
      @(negedge CLK_50M);
      RSTn      = rst_n;
      ps2_valid = v;
      ps2_byte  = b;
      k = k + 1;
      model_cycle(rst_n, v, b, x);
      q.push_back(x);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'($urandom));
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      step(1'b1, 1'b1, b);
      idle(gap);
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t x;
      forever begin
         @(posedge CLK_50M);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (key_held !== x.held) begin
               failures++;
               $display("FAIL key_held cyc=%0d got=%b exp=%b", x.cyc, key_held, x.held);
            end
            checks++;
            if (key_pulse !== x.pulse) begin
               failures++;
               $display("FAIL key_pulse cyc=%0d got=%b exp=%b", x.cyc, key_pulse, x.pulse);
            end
            checks++;
            if (key_release !== x.rel) begin
               failures++;
               $display("FAIL key_release cyc=%0d got=%b exp=%b", x.cyc, key_release, x.rel);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] pool [9] = '{8'h1C, 8'h1B, 8'h23, 8'h1D, 8'h6B, 8'hE0, 8'hF0, 8'hE1, 8'h55};

   initial begin
      // reset state
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h1C);

      // press/release of ch0
      send(8'h1C, 2); send(8'hF0, 1); send(8'h1C, 3);

      // auto-repeat on ch2, then stop on release
      send(8'h23, 24); send(8'hF0, 2); send(8'h23, 12);

      // extended code on ch4
      send(8'h6B, 2);
      send(8'hE0, 1); send(8'h6B, 3);
      send(8'hE0, 0); send(8'hF0, 0); send(8'h6B, 3);

      // prefix timeout boundary: TMO idle discards, TMO-1 idle keeps
      send(8'hF0, TMO); send(8'h1C, 3);
      send(8'hF0, TMO - 1); send(8'h1C, 3);

      // retarget: hold ch0, press ch3, release ch3
      send(8'h1C, 5); send(8'h1D, 20); send(8'hF0, 1); send(8'h1D, 20);
      send(8'hF0, 1); send(8'h1C, 3);

      // reset during repeat of ch1; later break is ignored
      send(8'h1B, 12);
      step(1'b0, 1'b0, 8'h00);
      idle(2); send(8'hF0, 1); send(8'h1B, 5);

      // typematic makes on a held key do not disturb the repeat schedule
      send(8'h23, 2);
      for (int i = 0; i < 6; i++) send(8'h23, 2);
      send(8'hF0, 0); send(8'h23, 3);

      // E1 inside a prefix, E0 in BRK taken as a break code
      send(8'h1C, 1); send(8'hF0, 0); send(8'hE1, 0); send(8'h1C, 2);
      send(8'hF0, 0); send(8'hE0, 0); send(8'h1B, 3);

      // reset mid-prefix: next byte is parsed from IDLE
      send(8'hF0, 0); step(1'b0, 1'b0, 8'h00); send(8'h1B, 3);
      send(8'hF0, 0); send(8'h1B, 2);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 1)       step(1'b0, 1'($urandom), 8'($urandom));
         else if (r < 4)  idle($urandom_range(TMO - 1, TMO + 2));
         else if (r < 40) step(1'b1, 1'b1, pool[$urandom_range(0, 8)]);
         else             step(1'b1, 1'b0, 8'($urandom));
      end
      idle(3);

      for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge CLK_50M);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
